// File: rtl/tx_control_if.sv
// Signal bundle between the result/rx-control side, tx_control and uart_tx.
// tx_control connects through the master modport; the environment uses slave.
interface tx_control_if #(
   parameter int RESULT_WIDTH = 16
);
   // Handshake: tx_trigger is a one-cycle request, accepted only while busy=0.
   // tx_start is a one-cycle strobe issued only while tx_busy=0; uart_tx
   // acknowledges by raising tx_busy, and the frame is complete when it falls.
   logic                    tx_trigger;
   logic [RESULT_WIDTH-1:0] result;
   logic                    tx_busy;
   logic                    tx_start;
   logic [7:0]              tx_data;
   logic                    busy;
   logic                    done;
   logic                    overrun;
   logic [2:0]              state_dbg;

   modport master (
      input  tx_trigger, result, tx_busy,
      output tx_start, tx_data, busy, done, overrun, state_dbg
   );

   modport slave (
      output tx_trigger, result, tx_busy,
      input  tx_start, tx_data, busy, done, overrun, state_dbg
   );
endinterface

// File: rtl/tx_control.sv
// Transmit sequencer: snapshots the ALU result and sends it LSB-first to uart_tx.
// Optional macro TX_CHECKSUM_EN appends an XOR checksum byte after the result.
module tx_control #(
   parameter int RESULT_WIDTH = 16,
   parameter int ACK_TIMEOUT  = 15
) (
   input  logic          clk,
   input  logic          reset,
   tx_control_if.master  bus
);
   localparam int NBYTES = RESULT_WIDTH / 8;
   localparam int CW     = $clog2(NBYTES + 1);
`ifdef TX_CHECKSUM_EN
   localparam int LAST_IDX = NBYTES;
`else
   localparam int LAST_IDX = NBYTES - 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SEND      = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [CW-1:0]           byte_cnt;
   logic [RESULT_WIDTH-1:0] snapshot;
   logic [7:0]              ack_timer;
   logic [7:0]              cur_byte;
   logic                    overrun_q;
   logic                    tx_start_c;
   logic                    timeout_hit;
   logic                    last_byte;

   assign timeout_hit = (ack_timer == 8'(ACK_TIMEOUT - 1));
   assign last_byte   = (byte_cnt == CW'(LAST_IDX));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      tx_start_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.tx_trigger) state_next = S_SEND;
         end
         S_SEND: begin
            // Holding here while tx_busy is high lets a previous frame drain.
            if (!bus.tx_busy) begin
               tx_start_c = 1'b1;
               state_next = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (bus.tx_busy)      state_next = S_WAIT_DONE;
            else if (timeout_hit) state_next = S_SEND;
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) state_next = last_byte ? S_DONE : S_SEND;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt  <= '0;
         snapshot  <= '0;
         ack_timer <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (bus.tx_trigger) begin
            if (state == S_IDLE) begin
               snapshot <= bus.result;
               byte_cnt <= '0;
            end else begin
               overrun_q <= 1'b1;
            end
         end
         if (state == S_SEND && !bus.tx_busy) begin
            ack_timer <= '0;
         end
         if (state == S_WAIT_ACK && !bus.tx_busy && !timeout_hit) begin
            ack_timer <= ack_timer + 8'd1;
         end
         if (state == S_WAIT_DONE && !bus.tx_busy && !last_byte) begin
            byte_cnt <= byte_cnt + CW'(1);
         end
      end
   end

`ifdef TX_CHECKSUM_EN
   logic [7:0] checksum;

   always_comb begin
      checksum = '0;
      for (int i = 0; i < NBYTES; i++) begin
         checksum = checksum ^ snapshot[8*i +: 8];
      end
   end
`endif

   // Constant-index mux keeps the byte select in range for any RESULT_WIDTH.
   always_comb begin
      cur_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (byte_cnt == CW'(i)) cur_byte = snapshot[8*i +: 8];
      end
`ifdef TX_CHECKSUM_EN
      if (byte_cnt == CW'(NBYTES)) cur_byte = checksum;
`endif
   end

   assign bus.tx_start  = tx_start_c;
   assign bus.tx_data   = (state == S_SEND || state == S_WAIT_ACK || state == S_WAIT_DONE)
                          ? cur_byte : 8'h00;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.overrun   = overrun_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_tx_control.sv
// Directed bench for tx_control with a behavioural uart_tx busy model.
// Covers latency, byte order, busy hold-off, ack timeout, overrun and reset.
module tb_tx_control;
   localparam int RW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tx_control_if #(.RESULT_WIDTH(RW)) bus ();

   tx_control #(.RESULT_WIDTH(RW), .ACK_TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   logic uart_busy   = 1'b0;
   logic hold_busy   = 1'b0;
   int   model_starts = 0;
   int   ignore_idx   = -1;

   assign bus.tx_busy = uart_busy | hold_busy;

   always @(posedge clk) cyc++;

   // uart_tx model: busy rises one cycle after tx_start and stays high 10 cycles.
   always begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
         if (model_starts == ignore_idx) begin
            model_starts++;
         end else begin
            model_starts++;
            @(posedge clk);
            #1 uart_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 uart_busy = 1'b0;
         end
      end
   end

   logic [7:0] got_q[$];
   int         got_cyc[$];
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         got_q.push_back(bus.tx_data);
         got_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input logic [RW-1:0] res);
      bus.result     = res;
      bus.tx_trigger = 1'b1;
      tick();
      bus.tx_trigger = 1'b0;
   endtask

   task automatic set_exp2(input logic [7:0] b0, input logic [7:0] b1);
      exp_q.delete();
      exp_q.push_back(b0);
      exp_q.push_back(b1);
`ifdef TX_CHECKSUM_EN
      exp_q.push_back(b0 ^ b1);
`endif
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      tick();
      check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_bytes(input string tag, input int base);
      check({tag, "_byte_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < got_q.size())
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[base + i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bad;
      bus.tx_trigger = 1'b0;
      bus.result     = '0;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_state", 32'(bus.state_dbg), 32'd0);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'h00);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);

      // Basic transfer, one-cycle trigger-to-start latency, result changed afterwards
      base = got_q.size();
      set_exp2(8'hC3, 8'hA5);
      pulse(16'hA5C3);
      check("a_busy", 32'(bus.busy), 32'd1);
      check("a_min_latency_start", 32'(bus.tx_start), 32'd1);
      check("a_first_data", 32'(bus.tx_data), 32'hC3);
      bus.result = 16'hFFFF;
      wait_done("a", 300);
      check("a_overrun", 32'(bus.overrun), 32'd0);
      check("a_idle_data", 32'(bus.tx_data), 32'h00);
      check_bytes("a", base);

      // tx_busy already high at the trigger, released five cycles later
      base = got_q.size();
      set_exp2(8'hC3, 8'hA5);
      hold_busy = 1'b1;
      pulse(16'hA5C3);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.tx_start !== 1'b0) bad++;
         if (i < 4) tick();
      end
      check("b_no_start_while_busy", 32'(bad), 32'd0);
      check("b_held_in_send", 32'(bus.state_dbg), 32'd1);
      @(posedge clk);
      #1 hold_busy = 1'b0;
      tick();
      check("b_start_on_release", 32'(bus.tx_start), 32'd1);
      check("b_data_on_release", 32'(bus.tx_data), 32'hC3);
      wait_done("b", 300);
      check_bytes("b", base);

      // First tx_start ignored: reissue after the ack timeout with the same byte
      base = got_q.size();
      exp_q.delete();
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'hC3);
      exp_q.push_back(8'hA5);
`ifdef TX_CHECKSUM_EN
      exp_q.push_back(8'h66);
`endif
      ignore_idx = model_starts;
      pulse(16'hA5C3);
      wait_done("c", 400);
      ignore_idx = -1;
      check_bytes("c", base);
      if (got_cyc.size() >= base + 2)
         check("c_retry_spacing", 32'(got_cyc[base + 1] - got_cyc[base]), 32'd16);
      else
         check("c_retry_present", 32'(got_cyc.size() - base), 32'd2);

      // Second trigger while the first byte is in flight
      base = got_q.size();
      set_exp2(8'hC3, 8'hA5);
      pulse(16'hA5C3);
      repeat (3) tick();
      check("d_overrun_before", 32'(bus.overrun), 32'd0);
      pulse(16'h1234);
      check("d_overrun_set", 32'(bus.overrun), 32'd1);
      wait_done("d", 300);
      check_bytes("d", base);
      repeat (5) tick();
      check("d_overrun_sticky", 32'(bus.overrun), 32'd1);

      // Reset during WAIT_DONE of byte 0 abandons the transfer
      pulse(16'hA5C3);
      repeat (4) tick();
      check("e_in_wait_done", 32'(bus.state_dbg), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("e_rst_state", 32'(bus.state_dbg), 32'd0);
      check("e_rst_busy", 32'(bus.busy), 32'd0);
      check("e_rst_done", 32'(bus.done), 32'd0);
      check("e_rst_data", 32'(bus.tx_data), 32'h00);
      check("e_rst_overrun", 32'(bus.overrun), 32'd0);
      base = got_q.size();
      repeat (20) tick();
      check("e_no_start_after_reset", 32'(got_q.size() - base), 32'd0);
      set_exp2(8'hFF, 8'h00);
      pulse(16'h00FF);
      wait_done("e", 300);
      check_bytes("e", base);
      check("e_overrun_clear", 32'(bus.overrun), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/tx_control.md
Name: tx_control

Overview:
Transmit-side sequencer for the UART calculator datapath. It is the counterpart of the receive-side control FSM, which collects the operand bytes and the command byte. On a single-cycle trigger, the block snapshots the RESULT_WIDTH-bit ALU result. It then hands the result to the UART transmitter one byte at a time, LSB first, using a start/busy handshake. It sits between the ALU result register and uart_tx.

Parameters:
RESULT_WIDTH, 16, width of result word; must be a multiple of 8 and at least 8; NBYTES = RESULT_WIDTH/8
ACK_TIMEOUT, 15, max cycles waited in WAIT_ACK for tx_busy to rise before re-issuing the current byte; 1..255

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
tx_trigger  input  1  one-cycle request to send the result (from rx control)
result  input  RESULT_WIDTH  result word; sampled only on an accepted trigger
tx_busy  input  1  uart_tx busy flag; high while a frame is being shifted out
tx_start  output  1  one-cycle start strobe to uart_tx
tx_data  output  8  byte presented to uart_tx
busy  output  1  high from the cycle after an accepted trigger until DONE exits
done  output  1  one-cycle pulse after the last byte's frame completes
overrun  output  1  sticky; set when tx_trigger arrives while busy=1; cleared only by reset

Behaviour:
- Reset (sync, applies at the posedge):
  - state=IDLE, byte_cnt=0, snapshot=0, ack timer=0.
  - Outputs: tx_start=0, tx_data=8'h00, busy=0, done=0, overrun=0.
  - Reset mid-transfer abandons the transfer. No further tx_start is issued.
- States: IDLE, SEND, WAIT_ACK, WAIT_DONE, DONE.
- IDLE:
  - busy=0.
  - When tx_trigger=1: snapshot<=result, byte_cnt<=0, go to SEND.
- SEND:
  - tx_data = snapshot byte[byte_cnt], i.e. snapshot[8*byte_cnt +: 8].
  - If tx_busy=0: tx_start=1 for this cycle (combinational from state and tx_busy), timer<=0, go to WAIT_ACK.
  - If tx_busy=1: hold in SEND, tx_start=0. This covers a frame still finishing from a previous transaction.
- WAIT_ACK:
  - tx_start=0.
  - If tx_busy=1: go to WAIT_DONE.
  - Else timer++. When timer reaches ACK_TIMEOUT, go back to SEND and re-issue the same byte.
- WAIT_DONE:
  - When tx_busy=0:
    - if byte_cnt==NBYTES-1, go to DONE;
    - else byte_cnt++ and go to SEND.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- tx_data is held stable from SEND through WAIT_DONE for the current byte. tx_data=8'h00 in IDLE.
- busy=1 in SEND, WAIT_ACK, WAIT_DONE and DONE.
- Trigger handling outside IDLE:
  - tx_trigger in any non-IDLE state is ignored and sets overrun; the snapshot is not modified.
  - tx_trigger in the same cycle that DONE is active also sets overrun.
- Minimum latency: trigger edge to first tx_start is 1 cycle (tx_start is high in the first SEND cycle when tx_busy=0).
- Back-to-back bytes: the next tx_start is issued 1 cycle after tx_busy falls.
- byte_cnt width is $clog2(NBYTES+1). It never wraps, since it is reloaded to 0 on each accepted trigger.
- result changing after the trigger has no effect on the bytes sent.

Optional Feature:
Macro TX_CHECKSUM_EN.
- Defined:
  - After the last result byte, one extra byte is sent: checksum = XOR of all NBYTES snapshot bytes.
  - byte_cnt runs 0..NBYTES, and the DONE condition becomes byte_cnt==NBYTES.
  - Timeout and retry rules also apply to the checksum byte.
- Undefined: exactly NBYTES bytes are sent; no checksum logic is synthesized.

Test Plan:
- reset; result=16'hA5C3; tx_trigger pulse; UART model raises tx_busy 1 cycle after each tx_start and holds it 10 cycles -> tx_start twice with tx_data=8'hC3 then 8'hA5, then done=1 for one cycle, busy=0 afterwards, overrun=0.
- Same stimulus with TX_CHECKSUM_EN defined -> bytes C3, A5, 66, then done.
- tx_busy already high when the trigger arrives, released 5 cycles later -> no tx_start while busy; first tx_start in the cycle tx_busy=0 is seen; byte 8'hC3.
- UART model ignores the first tx_start (tx_busy stays 0) -> after 15 cycles in WAIT_ACK, a second tx_start is issued with the same tx_data=8'hC3; the transfer then completes normally.
- Second tx_trigger with result=16'h1234 while the first byte is in flight -> overrun=1 and stays set; transmitted bytes remain C3, A5; overrun clears only after reset.
- reset asserted during WAIT_DONE of byte 0 -> next cycle state IDLE, busy=0, done=0, tx_data=00; no further tx_start; a new trigger with 16'h00FF sends FF then 00.
